// File: rtl/hazard_sched_if.sv
// rtl/hazard_sched_if.sv - D-stage hazard request/response bundle; stall_cnt present when HAZ_STALL_CNT_EN is defined
interface hazard_sched_if;
    logic [4:0]  ra1_d;
    logic [4:0]  ra2_d;
    logic [4:0]  wa_d;
    logic [2:0]  res_d;
    logic [1:0]  tuse1_d;
    logic [1:0]  tuse2_d;
    logic        md_use_d;
    logic        md_start_e;
    logic        md_div_e;
    logic        stall_d;
    logic        flush_e;
    logic [1:0]  fwd_rs_d;
    logic [1:0]  fwd_rt_d;
    logic [1:0]  fwd_rs_e;
    logic [1:0]  fwd_rt_e;
    logic        fwd_rt_m;
    logic        md_busy;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    modport master (
        output ra1_d, ra2_d, wa_d, res_d, tuse1_d, tuse2_d,
        output md_use_d, md_start_e, md_div_e,
`ifdef HAZ_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  stall_d, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
        input  fwd_rt_m, md_busy
    );

    modport slave (
        input  ra1_d, ra2_d, wa_d, res_d, tuse1_d, tuse2_d,
        input  md_use_d, md_start_e, md_div_e,
`ifdef HAZ_STALL_CNT_EN
        output stall_cnt,
`endif
        output stall_d, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
        output fwd_rt_m, md_busy
    );
endinterface

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - MIPS 5-stage stall/flush/forward controller with mult/div busy counter; HAZ_STALL_CNT_EN adds stall_cnt
module hazard_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_sched_if.slave  bus
);

    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_MD  = 3'd4;
    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    // Only the tag fields that some hazard check reads are kept per stage.
    logic [4:0] e_ra1, e_ra2, e_wa, m_ra2, m_wa, w_wa;
    logic [2:0] e_res, m_res, w_res;
    logic [3:0] md_cnt;

    logic [1:0] tnew_e, tnew_m;
    logic       rs_hit_e, rs_hit_m, rs_hit_w;
    logic       rt_hit_e, rt_hit_m, rt_hit_w;
    logic       stall_rs, stall_rt, stall_md, stall;

    function automatic logic [1:0] tnew_at_e(input logic [2:0] res);
        case (res)
            RES_ALU, RES_MD: return 2'd1;
            RES_DM:          return 2'd2;
            default:         return 2'd0;
        endcase
    endfunction

    function automatic logic hit(input logic [4:0] src, input logic [4:0] wa,
                                 input logic [2:0] res);
        return (src != 5'd0) && (src == wa) && (res != RES_NW);
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic he, input logic hm,
                                             input logic hw, input logic [1:0] te,
                                             input logic [1:0] tm);
        if (he && te == 2'd0)      return 2'd1;
        else if (hm && tm == 2'd0) return 2'd2;
        else if (hw)               return 2'd3;
        else                       return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] src, input logic [1:0] tm);
        if (hit(src, m_wa, m_res) && tm == 2'd0) return 2'd2;
        else if (hit(src, w_wa, w_res))          return 2'd3;
        else                                     return 2'd0;
    endfunction

    always_comb begin
        tnew_e   = tnew_at_e(e_res);
        tnew_m   = (tnew_at_e(m_res) == 2'd0) ? 2'd0 : tnew_at_e(m_res) - 2'd1;
        rs_hit_e = hit(bus.ra1_d, e_wa, e_res);
        rs_hit_m = hit(bus.ra1_d, m_wa, m_res);
        rs_hit_w = hit(bus.ra1_d, w_wa, w_res);
        rt_hit_e = hit(bus.ra2_d, e_wa, e_res);
        rt_hit_m = hit(bus.ra2_d, m_wa, m_res);
        rt_hit_w = hit(bus.ra2_d, w_wa, w_res);
        stall_rs = (bus.tuse1_d != 2'd3) &&
                   ((rs_hit_e && tnew_e > bus.tuse1_d) || (rs_hit_m && tnew_m > bus.tuse1_d));
        stall_rt = (bus.tuse2_d != 2'd3) &&
                   ((rt_hit_e && tnew_e > bus.tuse2_d) || (rt_hit_m && tnew_m > bus.tuse2_d));
        stall_md = bus.md_use_d && ((md_cnt != 4'd0) || bus.md_start_e);
        // Tags are already clear during reset; md_start_e is the only path left to gate.
        stall    = rst_n && (stall_rs || stall_rt || stall_md);
    end

    assign bus.stall_d  = stall;
    assign bus.flush_e  = stall;
    assign bus.fwd_rs_d = fwd_d_sel(rs_hit_e, rs_hit_m, rs_hit_w, tnew_e, tnew_m);
    assign bus.fwd_rt_d = fwd_d_sel(rt_hit_e, rt_hit_m, rt_hit_w, tnew_e, tnew_m);
    assign bus.fwd_rs_e = fwd_e_sel(e_ra1, tnew_m);
    assign bus.fwd_rt_e = fwd_e_sel(e_ra2, tnew_m);
    assign bus.fwd_rt_m = hit(m_ra2, w_wa, w_res);
    assign bus.md_busy  = (md_cnt != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ra1 <= '0; e_ra2 <= '0; e_wa <= '0; e_res <= RES_NW;
            m_ra2 <= '0; m_wa  <= '0; m_res <= RES_NW;
            w_wa  <= '0; w_res <= RES_NW;
        end else begin
            e_ra1 <= stall ? 5'd0 : bus.ra1_d;
            e_ra2 <= stall ? 5'd0 : bus.ra2_d;
            e_wa  <= stall ? 5'd0 : bus.wa_d;
            e_res <= stall ? RES_NW : bus.res_d;
            m_ra2 <= e_ra2;
            m_wa  <= e_wa;
            m_res <= e_res;
            w_wa  <= m_wa;
            w_res <= m_res;
        end
    end

    // A start while still busy simply reloads; no sticky state to corrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            md_cnt <= 4'd0;
        else if (bus.md_start_e)
            md_cnt <= bus.md_div_e ? DIV_LD : MULT_LD;
        else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= 32'd0;
        else if (stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - directed vector table plus randomized run against a pipeline-history model
module tb_hazard_sched;

    typedef struct packed {
        logic [4:0] ra1, ra2, wa;
        logic [2:0] res;
        logic [1:0] t1, t2;
    } instr_t;

    typedef struct {
        logic        rstn;
        instr_t      d;
        logic        mduse, mdstart, mddiv;
        logic [11:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nfail = 0;

    hazard_sched_if hif();

    hazard_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif.slave)
    );

    always #5 clk = ~clk;

    // Model: pipe[age] is the instruction age+1 stages past D (0=E, 1=M, 2=W).
    instr_t      pipe [3];
    int          md_left;
    logic [31:0] scnt;

    function automatic int tnew(input logic [2:0] res, input int age);
        int base;
        base = (res == 3'd1 || res == 3'd4) ? 1 : (res == 3'd2) ? 2 : 0;
        return (base > age) ? base - age : 0;
    endfunction

    function automatic logic hits(input logic [4:0] src, input instr_t s);
        return src != 0 && src == s.wa && s.res != 0;
    endfunction

    function automatic logic [1:0] dsel(input logic [4:0] src);
        for (int a = 0; a < 3; a++)
            if (hits(src, pipe[a]) && tnew(pipe[a].res, a) == 0) return 2'(a + 1);
        return 2'd0;
    endfunction

    function automatic logic [1:0] esel(input logic [4:0] src);
        for (int a = 1; a < 3; a++)
            if (hits(src, pipe[a]) && tnew(pipe[a].res, a) == 0) return 2'(a + 1);
        return 2'd0;
    endfunction

    function automatic logic [11:0] model_out(input logic rstn, input instr_t d,
                                              input logic mduse, input logic mdstart);
        logic stall;
        if (!rstn) return 12'd0;
        stall = 1'b0;
        for (int a = 0; a < 2; a++) begin
            if (d.t1 != 3 && hits(d.ra1, pipe[a]) && tnew(pipe[a].res, a) > int'(d.t1)) stall = 1'b1;
            if (d.t2 != 3 && hits(d.ra2, pipe[a]) && tnew(pipe[a].res, a) > int'(d.t2)) stall = 1'b1;
        end
        if (mduse && (md_left > 0 || mdstart)) stall = 1'b1;
        return {stall, stall, dsel(d.ra1), dsel(d.ra2), esel(pipe[0].ra1), esel(pipe[0].ra2),
                hits(pipe[1].ra2, pipe[2]), md_left > 0};
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 3; a++) pipe[a] = '0;
        md_left = 0;
        scnt    = 0;
    endtask

    task automatic model_step(input logic rstn, input instr_t d, input logic stall,
                              input logic mdstart, input logic mddiv);
        if (!rstn) begin
            model_reset();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = stall ? '0 : d;
            if (mdstart) md_left = mddiv ? 10 : 5;
            else if (md_left > 0) md_left--;
            if (stall && scnt != 32'hFFFF_FFFF) scnt++;
        end
    endtask

    function automatic logic [11:0] dut_out();
        return {hif.stall_d, hif.flush_e, hif.fwd_rs_d, hif.fwd_rt_d, hif.fwd_rs_e,
                hif.fwd_rt_e, hif.fwd_rt_m, hif.md_busy};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %03h want %03h", name, got, want);
        end
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic apply(input string name, input logic rstn, input instr_t d, input logic mduse,
                         input logic mdstart, input logic mddiv, input logic [11:0] exp,
                         input bit use_model);
        logic [11:0] m;
        rst_n          = rstn;
        hif.ra1_d      = d.ra1;  hif.ra2_d   = d.ra2;  hif.wa_d = d.wa;
        hif.res_d      = d.res;  hif.tuse1_d = d.t1;   hif.tuse2_d = d.t2;
        hif.md_use_d   = mduse;  hif.md_start_e = mdstart; hif.md_div_e = mddiv;
        #1;
        m = model_out(rstn, d, mduse, mdstart);
        check(name, dut_out(), use_model ? m : exp);
        @(posedge clk);
        model_step(rstn, d, m[11], mdstart, mddiv);
        @(negedge clk);
    endtask

    function automatic instr_t mk(input int ra1, input int ra2, input int wa, input int res,
                                  input int t1, input int t2);
        return '{ra1: 5'(ra1), ra2: 5'(ra2), wa: 5'(wa), res: 3'(res), t1: 2'(t1), t2: 2'(t2)};
    endfunction

    function automatic logic [4:0] rreg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    vec_t   tbl [$];
    instr_t nop, mfhi, ri;

    task automatic add(input logic rstn, input instr_t d, input logic mduse, input logic mdstart,
                       input logic mddiv, input logic [11:0] exp);
        vec_t v;
        v.rstn = rstn; v.d = d; v.mduse = mduse; v.mdstart = mdstart; v.mddiv = mddiv; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        nop  = mk(0, 0, 0, 0, 3, 3);
        mfhi = mk(0, 0, 12, 4, 3, 3);
        // exp = {stall, flush, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy}
        add(0, mk(8, 9, 8, 2, 0, 0), 1, 1, 1, 12'h000);  // reset with live inputs
        add(1, nop,                  0, 0, 0, 12'h000);
        add(1, mk(29, 0, 8, 2, 1, 3), 0, 0, 0, 12'h000); // lw $8
        add(1, mk(8, 10, 9, 1, 1, 1), 0, 0, 0, 12'hC00); // load-use stall
        add(1, mk(8, 10, 9, 1, 1, 1), 0, 0, 0, 12'h000); // lw in M, released
        add(1, nop,                  0, 0, 0, 12'h030); // addu in E takes lw from W
        add(1, nop,                  0, 0, 0, 12'h000);
        add(1, mk(1, 2, 5, 1, 1, 1),  0, 0, 0, 12'h000); // addu $5
        add(1, mk(5, 0, 0, 0, 0, 0),  0, 0, 0, 12'hC00); // beq $5 stalls
        add(1, mk(5, 0, 0, 0, 0, 0),  0, 0, 0, 12'h200); // forward from M
        add(1, mk(0, 0, 31, 3, 3, 3), 0, 0, 0, 12'h030); // jal; beq in E gets W
        add(1, mk(31, 0, 0, 0, 0, 3), 0, 0, 0, 12'h100); // jr $31 from E
        add(1, mk(3, 4, 0, 1, 1, 1),  0, 0, 0, 12'h020); // addu $0; jr in E gets M
        add(1, mk(0, 0, 6, 1, 0, 0),  0, 0, 0, 12'h000); // reads $0
        add(1, mk(29, 0, 7, 2, 1, 3), 0, 0, 0, 12'h000); // lw $7
        add(1, mk(29, 7, 0, 0, 1, 2), 0, 0, 0, 12'h000); // sw $7, tuse 2
        add(1, nop,                  0, 0, 0, 12'h000);
        add(1, nop,                  0, 0, 0, 12'h002); // store data from W
        add(1, mfhi,                 1, 1, 1, 12'hC00); // div issues
        for (int i = 0; i < 10; i++) add(1, mfhi, 1, 0, 0, 12'hC01);
        add(1, mfhi,                 1, 0, 0, 12'h000);

        rst_n = 1'b0;
        hif.ra1_d = '0; hif.ra2_d = '0; hif.wa_d = '0; hif.res_d = '0;
        hif.tuse1_d = 2'd3; hif.tuse2_d = 2'd3;
        hif.md_use_d = 1'b0; hif.md_start_e = 1'b0; hif.md_div_e = 1'b0;
        model_reset();
        @(negedge clk);

        foreach (tbl[i])
            apply($sformatf("tbl%0d", i), tbl[i].rstn, tbl[i].d, tbl[i].mduse,
                  tbl[i].mdstart, tbl[i].mddiv, tbl[i].exp, 1'b0);

        // Asynchronous reset while the divider is counting.
        apply("md_issue", 1, nop, 0, 1, 1, 12'h000, 1'b0);
        for (int i = 0; i < 3; i++) apply($sformatf("md_run%0d", i), 1, nop, 0, 0, 0, 12'h001, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("md_async_rst", dut_out(), 12'h000);
        model_reset();
        @(negedge clk);
        apply("md_after_rst", 1, nop, 1, 0, 0, 12'h000, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            ri = mk(rreg(), rreg(), rreg(), $urandom_range(0, 4),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            apply($sformatf("rnd%0d", n), ($urandom_range(0, 299) != 0), ri,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)), 12'h000, 1'b1);
        end

`ifdef HAZ_STALL_CNT_EN
        #1;
        nvec++;
        if (hif.stall_cnt !== scnt) begin
            nfail++;
            $display("FAIL stall_cnt: got %0d want %0d", hif.stall_cnt, scnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
